// File: rtl/dst7_1d_seq.sv
// ---------------------------------------------------------------------------
// dst7_1d_seq
// Multi-size (N = 4/8/16) time-multiplexed 1-D DST-7 forward transform.
// One input vector is latched per transaction; output coefficients are
// streamed ROWS rows per cycle through a valid/ready output register.
//
// Configuration macro: DST7_SEQ_SAT_EN
//   defined   : each row result is clipped to the signed OUT_W range
//   undefined : each row result keeps its OUT_W LSBs (two's-complement wrap)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   input vector valid
//   in_ready   engine idle, can accept a vector
//   in_size    00 = N4, 01 = N8, 10/11 = N16
//   in_data    X[n] = in_data[n*IN_W +: IN_W], lanes n >= N ignored
//   out_valid  output group valid
//   out_ready  downstream accepts the group
//   out_idx    row index of lane 0 of the group
//   out_last   last group of the vector
//   out_data   Y[out_idx+r] = out_data[r*OUT_W +: OUT_W]
// ---------------------------------------------------------------------------
module dst7_1d_seq #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16,
    parameter int ROWS  = 4,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_size,
    input  logic [16*IN_W-1:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_idx,
    output logic                    out_last,
    output logic [ROWS*OUT_W-1:0]   out_data
);

    localparam int ACC_W = IN_W + 12;
    // Rounding offset: half an LSB of the shifted result, zero when SHIFT = 0.
    localparam int RND   = (32'sd1 <<< SHIFT) >>> 1;

    // Basis tables packed LSB-first: entry j-1 sits at bits [8*(j-1) +: 8].
    localparam logic [31:0]  T4_P  = {8'd84, 8'd74, 8'd55, 8'd29};
    localparam logic [63:0]  T8_P  = {8'd86, 8'd85, 8'd78, 8'd71, 8'd60, 8'd46, 8'd32, 8'd17};
    localparam logic [127:0] T16_P = {8'd45, 8'd44, 8'd43, 8'd42, 8'd41, 8'd39, 8'd36, 8'd34,
                                      8'd31, 8'd28, 8'd24, 8'd20, 8'd17, 8'd13, 8'd8,  8'd4};

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_r;
    logic [1:0]             size_r;
    logic [16*IN_W-1:0]     data_r;
    logic [3:0]             g_r;

    logic [ROWS*OUT_W-1:0]  grp_s;
    logic [3:0]             idx_s;
    logic                   last_s;
    int                     n_s;
    int                     groups_s;

    function automatic int size_n_f(input logic [1:0] sz);
        int nn;
        case (sz)
            2'b00:   nn = 32'sd4;
            2'b01:   nn = 32'sd8;
            default: nn = 32'sd16;
        endcase
        return nn;
    endfunction

    // Signed matrix entry c[k][n]; the modulus is a per-size constant.
    function automatic int coef_f(input logic [1:0] sz, input int k, input int n);
        int           nn, mm, p, j, t, c, prod;
        logic         neg;
        logic [127:0] tbl;
        nn   = size_n_f(sz);
        mm   = 32'sd2 * nn + 32'sd1;
        prod = (32'sd2 * k + 32'sd1) * (n + 32'sd1);
        case (sz)
            2'b00:   begin p = prod % 32'sd18; tbl = {96'd0, T4_P}; end
            2'b01:   begin p = prod % 32'sd34; tbl = {64'd0, T8_P}; end
            default: begin p = prod % 32'sd66; tbl = T16_P;         end
        endcase
        if (p == 32'sd0 || p == mm) begin
            c = 32'sd0;
        end else begin
            if (p < mm) begin
                j   = p;
                neg = 1'b0;
            end else begin
                j   = p - mm;
                neg = 1'b1;
            end
            // Fold the index back into the half-period covered by the table.
            if (j > nn) begin
                j = mm - j;
            end else begin
                j = j;
            end
            tbl = tbl >> (32'sd8 * (j - 32'sd1));
            t   = int'(tbl[7:0]);
            c   = neg ? -t : t;
        end
        return c;
    endfunction

    // Full-precision dot product of row k with the latched vector.
    function automatic logic signed [ACC_W-1:0] row_sum_f(input logic [1:0] sz,
                                                          input logic [16*IN_W-1:0] d,
                                                          input int k);
        int nn, acc;
        logic signed [IN_W-1:0] x;
        nn  = size_n_f(sz);
        acc = 32'sd0;
        for (int n = 0; n < 16; n++) begin
            x = d[n*IN_W +: IN_W];
            if (n < nn) begin
                acc = acc + coef_f(sz, k, n) * int'(x);
            end else begin
                acc = acc;
            end
        end
        return ACC_W'(acc);
    endfunction

    // Rounding right shift followed by clip or wrap to OUT_W.
    function automatic logic [OUT_W-1:0] scale_f(input logic signed [ACC_W-1:0] acc);
        int y;
        logic [OUT_W-1:0] r;
        y = (int'(acc) + RND) >>> SHIFT;
`ifdef DST7_SEQ_SAT_EN
        if (y > ((32'sd1 <<< (OUT_W - 1)) - 32'sd1)) begin
            r = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (y < -(32'sd1 <<< (OUT_W - 1))) begin
            r = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = OUT_W'(y);
        end
`else
        r = OUT_W'(y);
`endif
        return r;
    endfunction

    // Row group g of the latched vector, with its index and last flag.
    always_comb begin
        n_s = size_n_f(size_r);
        if (n_s > ROWS) begin
            groups_s = n_s / ROWS;
        end else begin
            groups_s = 32'sd1;
        end
        idx_s  = 4'(int'(g_r) * ROWS);
        last_s = (int'(g_r) == groups_s - 32'sd1);
        grp_s  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(g_r) * ROWS + r < n_s) begin
                grp_s[r*OUT_W +: OUT_W] = scale_f(row_sum_f(size_r, data_r, int'(g_r) * ROWS + r));
            end else begin
                grp_s[r*OUT_W +: OUT_W] = '0;
            end
        end
    end

    // Control FSM, vector latch and output register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            size_r    <= 2'b00;
            data_r    <= '0;
            g_r       <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= out_valid;
                    end
                    if (in_valid) begin
                        data_r   <= in_data;
                        size_r   <= in_size;
                        g_r      <= 4'd0;
                        state_r  <= BUSY;
                        in_ready <= 1'b0;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    in_ready <= 1'b0;
                    // Load only when the output register is empty or draining.
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        out_data  <= grp_s;
                        out_idx   <= idx_s;
                        out_last  <= last_s;
                        g_r       <= g_r + 4'd1;
                        if (last_s) begin
                            state_r  <= IDLE;
                            in_ready <= 1'b1;
                        end else begin
                            state_r  <= BUSY;
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dst7_1d_seq.sv
// ---------------------------------------------------------------------------
// tb_dst7_1d_seq
// Self-checking bench for dst7_1d_seq: a vector table with expected rows,
// a group scoreboard fed on accept and drained by an output monitor, and
// hand-written sequences for backpressure, mid-vector reset, the rounding
// shift (second instance with SHIFT = 2) and back-to-back acceptance.
// ---------------------------------------------------------------------------
module tb_dst7_1d_seq;

    localparam int IN_W  = 9;
    localparam int OUT_W = 16;
    localparam int ROWS  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_size;
    logic [16*IN_W-1:0]    in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_idx;
    logic                  out_last;
    logic [ROWS*OUT_W-1:0] out_data;

    logic                  s2_in_ready;
    logic                  s2_out_valid;
    logic [3:0]            s2_out_idx;
    logic                  s2_out_last;
    logic [ROWS*OUT_W-1:0] s2_out_data;

    typedef struct packed {
        logic [1:0]         size;
        logic [16*IN_W-1:0] data;
        logic [16*OUT_W-1:0] y;
    } vec_rec_t;

    typedef struct packed {
        logic [3:0]            idx;
        logic                  last;
        logic [ROWS*OUT_W-1:0] data;
    } grp_t;

    grp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    int spec1[16] = '{4, 13, 20, 28, 34, 39, 42, 44, 45, 43, 41, 36, 31, 24, 17, 8};
    int spec2[4]  = '{242, 74, 36, 16};
    int spec5[8]  = '{17, 46, 71, 85, 86, 78, 60, 32};

    dst7_1d_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .ROWS(ROWS), .SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_size(in_size), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
        .out_data(out_data)
    );

    dst7_1d_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .ROWS(ROWS), .SHIFT(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s2_in_ready),
        .in_size(in_size), .in_data(in_data), .out_valid(s2_out_valid),
        .out_ready(out_ready), .out_idx(s2_out_idx), .out_last(s2_out_last),
        .out_data(s2_out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int tb_n(input logic [1:0] sz);
        return (sz == 2'b00) ? 4 : ((sz == 2'b01) ? 8 : 16);
    endfunction

    function automatic int tb_t(input int nn, input int j);
        int t4[4]   = '{29, 55, 74, 84};
        int t8[8]   = '{17, 32, 46, 60, 71, 78, 85, 86};
        int t16[16] = '{4, 8, 13, 17, 20, 24, 28, 31, 34, 36, 39, 41, 42, 43, 44, 45};
        if (nn == 4) return t4[j-1];
        if (nn == 8) return t8[j-1];
        return t16[j-1];
    endfunction

    function automatic int tb_coef(input int nn, input int k, input int n);
        int mm, p, j, s;
        mm = 2 * nn + 1;
        p  = ((2 * k + 1) * (n + 1)) % (2 * mm);
        if (p == 0 || p == mm) return 0;
        if (p < mm) begin j = p; s = 1; end
        else begin j = p - mm; s = -1; end
        if (j > nn) j = mm - j;
        return s * tb_t(nn, j);
    endfunction

    function automatic int tb_y(input logic [1:0] sz, input logic [16*IN_W-1:0] d,
                                input int k, input int sh);
        int nn, acc;
        logic signed [IN_W-1:0] xs;
        logic signed [15:0] w;
        nn  = tb_n(sz);
        acc = 0;
        for (int n = 0; n < nn; n++) begin
            xs  = d[n*IN_W +: IN_W];
            acc = acc + tb_coef(nn, k, n) * int'(xs);
        end
        if (sh > 0) acc = (acc + (1 << (sh - 1))) >>> sh;
`ifdef DST7_SEQ_SAT_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc;
`else
        w = acc[15:0];
        return int'(w);
`endif
    endfunction

    function automatic vec_rec_t model_rec(input logic [1:0] sz, input logic [16*IN_W-1:0] d);
        vec_rec_t r;
        r.size = sz;
        r.data = d;
        r.y    = '0;
        for (int k = 0; k < tb_n(sz); k++) r.y[k*OUT_W +: OUT_W] = 16'(tb_y(sz, d, k, 0));
        return r;
    endfunction

    function automatic logic [16*IN_W-1:0] put_x(input logic [16*IN_W-1:0] d, input int n, input int v);
        logic [16*IN_W-1:0] r;
        r = d;
        r[n*IN_W +: IN_W] = 9'(v);
        return r;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic push_exp(input vec_rec_t rec);
        grp_t e;
        int   ng;
        ng = tb_n(rec.size) / ROWS;
        for (int g = 0; g < ng; g++) begin
            e.idx  = 4'(g * ROWS);
            e.last = (g == ng - 1);
            e.data = rec.y[g*ROWS*OUT_W +: ROWS*OUT_W];
            sb.push_back(e);
        end
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic send(input vec_rec_t rec);
        int cnt;
        cnt      = 0;
        in_size  = rec.size;
        in_data  = rec.data;
        in_valid = 1'b1;
        while (!in_ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("accept_wait", int'(in_ready), 1);
        push_exp(rec);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((sb.size() != 0 || out_valid) && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("drain_pending", sb.size(), 0);
        chk("drain_out_valid", int'(out_valid), 0);
    endtask

    // Output monitor: every handshake pops and checks one expected group.
    always @(negedge clk) begin
        grp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_group: got group idx %0d, expected none", out_idx);
            end else begin
                n_cmp--;
                e = sb.pop_front();
                chk("grp_idx", int'(out_idx), int'(e.idx));
                chk("grp_last", int'(out_last), int'(e.last));
                for (int r = 0; r < ROWS; r++) begin
                    chk($sformatf("grp_y[%0d]", int'(e.idx) + r),
                        int'($signed(out_data[r*OUT_W +: OUT_W])),
                        int'($signed(e.data[r*OUT_W +: OUT_W])));
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_rec_t           tbl[9];
        vec_rec_t           rec;
        logic [16*IN_W-1:0] d;
        int                 acc_cnt, last_acc, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_size   = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data_nonzero", int'(out_data != '0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        d = put_x('0, 0, 1);
        tbl[0].size = 2'b10; tbl[0].data = d; tbl[0].y = '0;
        for (int k = 0; k < 16; k++) tbl[0].y[k*OUT_W +: OUT_W] = 16'(spec1[k]);

        d = '0;
        for (int n = 0; n < 16; n++) d = put_x(d, n, (n < 4) ? 1 : 100);
        tbl[1].size = 2'b00; tbl[1].data = d; tbl[1].y = '0;
        for (int k = 0; k < 4; k++) tbl[1].y[k*OUT_W +: OUT_W] = 16'(spec2[k]);

        d = '0;
        for (int n = 0; n < 16; n++) d = put_x(d, n, 255);
        tbl[2] = model_rec(2'b10, d);
`ifdef DST7_SEQ_SAT_EN
        tbl[2].y[15:0] = 16'd32767;
`else
        tbl[2].y[15:0] = 16'(-11477);
`endif

        for (int i = 3; i < 7; i++) begin
            d = '0;
            for (int n = 0; n < 16; n++) d = put_x(d, n, int'($urandom_range(0, 511)) - 256);
            tbl[i] = model_rec(2'(i - 3), d);
        end

        d = put_x('0, 0, 1);
        tbl[7].size = 2'b01; tbl[7].data = d; tbl[7].y = '0;
        for (int k = 0; k < 8; k++) tbl[7].y[k*OUT_W +: OUT_W] = 16'(spec5[k]);

        d = '0;
        for (int n = 0; n < 16; n++) d = put_x(d, n, -256);
        tbl[8] = model_rec(2'b00, d);

        for (int i = 0; i < 9; i++) send(tbl[i]);
        wait_drain();

        // Latency of N4: first group visible two cycles after accept
        send(tbl[1]);
        chk("lat_cycle1_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_cycle2_valid", int'(out_valid), 1);
        chk("lat_cycle2_last", int'(out_last), 1);
        wait_drain();

        // Backpressure: hold idx 0 for 5 cycles, size/data changes while busy ignored
        out_ready = 1'b0;
        send(tbl[0]);
        in_size = 2'b00;
        in_data = '1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_idx", int'(out_idx), 0);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_y0", int'($signed(out_data[15:0])), 4);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_idx4", int'(out_idx), 4);
        @(posedge clk); #1;
        chk("bp_rel_idx8", int'(out_idx), 8);
        @(posedge clk); #1;
        chk("bp_rel_idx12", int'(out_idx), 12);
        chk("bp_rel_last", int'(out_last), 1);
        @(posedge clk); #1;
        chk("bp_done_valid", int'(out_valid), 0);
        chk("bp_done_in_ready", int'(in_ready), 1);
        wait_drain();

        // Reset while group idx 4 is pending
        send(tbl[0]);
        cyc = 0;
        while (!(out_valid && out_idx == 4'd4) && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("mid_rst_idx4_seen", int'(out_idx), 4);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_idx", int'(out_idx), 0);
        rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(tbl[7]);
        wait_drain();

        // Rounding shift instance (SHIFT = 2)
        for (int v = 0; v < 2; v++) begin
            rec = model_rec(2'b00, put_x('0, 0, (v == 0) ? 1 : -1));
            send(rec);
            cyc = 0;
            while (!s2_out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
            chk("s2_valid", int'(s2_out_valid), 1);
            for (int r = 0; r < 4; r++)
                chk($sformatf("s2_y[%0d]", r), int'($signed(s2_out_data[r*OUT_W +: OUT_W])),
                    tb_y(rec.size, rec.data, r, 2));
            wait_drain();
        end

        // Back-to-back N4 vectors with in_valid held high
        acc_cnt  = 0;
        last_acc = 0;
        cyc      = 0;
        rec      = model_rec(2'b00, put_x('0, 0, 3));
        in_size  = rec.size;
        in_data  = rec.data;
        in_valid = 1'b1;
        while (acc_cnt < 3 && cyc < 40) begin
            if (in_ready) begin
                push_exp(rec);
                if (acc_cnt > 0) chk("b2b_gap", cyc - last_acc, 2);
                last_acc = cyc;
                acc_cnt++;
                rec     = model_rec(2'b00, put_x(put_x('0, 1, acc_cnt + 5), 3, -acc_cnt));
                @(posedge clk); #1;
                cyc++;
                in_size = rec.size;
                in_data = rec.data;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", acc_cnt, 3);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
